// File: rtl/sram_pkg.sv
// Shared definitions for the half-word SRAM memory-stage controller.
package sram_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LOW,
        HIGH,
        DONE
    } state_e;

    localparam int SRAM_DATA_W       = 16;
    localparam int SRAM_ADDR_W       = 18;
    localparam int DEFAULT_BASE_ADDR = 1024;

endpackage

// File: rtl/sram_controller.sv
// 32-bit load/store responder performing each access as two 16-bit half cycles
// on an external asynchronous SRAM; ready stays low while an access is in flight.
module sram_controller
    import sram_pkg::*;
#(
    parameter int BASE_ADDR     = DEFAULT_BASE_ADDR,
    parameter int ACCESS_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   wr_en,
    input  logic                   rd_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [SRAM_DATA_W-1:0] SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_OE_N
);

    localparam int               CNT_W = $clog2(ACCESS_CYCLES) + 1;
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(ACCESS_CYCLES - 1);

    state_e                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic                   wr_q;
    logic                   we_n_q;
    logic [SRAM_ADDR_W-1:0] addr_q;
    logic [31:0]            rdata_q;
    logic [16:0]            word;
    logic                   last;

    // Out-of-range addresses simply wrap into the 2^17-word window.
    assign word = 17'((address - 32'(BASE_ADDR)) >> 2);
    assign last = (cnt_q == LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            wr_q    <= 1'b0;
            we_n_q  <= 1'b1;
            addr_q  <= '0;
            rdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (wr_en || rd_en) begin
                        state_q <= LOW;
                        cnt_q   <= '0;
                        wr_q    <= wr_en;
                        we_n_q  <= ~wr_en;
                        addr_q  <= {word, 1'b0};
                    end
                end
                LOW: begin
                    if (last) begin
                        state_q <= HIGH;
                        cnt_q   <= '0;
                        addr_q  <= {word, 1'b1};
                        if (!wr_q) rdata_q[15:0] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                HIGH: begin
                    if (last) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        we_n_q  <= 1'b1;
                        if (!wr_q) rdata_q[31:16] <= SRAM_DQ;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    // The bus is driven exactly while the write strobe is active, so reset releases it at once.
    assign SRAM_DQ = we_n_q ? {SRAM_DATA_W{1'bz}}
                            : ((state_q == HIGH) ? write_data[31:16] : write_data[15:0]);

    assign ready     = (state_q == DONE) || ((state_q == IDLE) && !rd_en && !wr_en);
    assign read_data = rdata_q;
    assign SRAM_ADDR = addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_UB_N = 1'b0;
    assign SRAM_LB_N = 1'b0;
    assign SRAM_CE_N = 1'b0;
    assign SRAM_OE_N = 1'b0;

endmodule

// File: doc/sram_controller.md
# sram_controller

Memory-stage responder for the pipelined ARM core: accepts one 32-bit load/store per request from the MEM stage, with the address computed by the execute-stage ALU. It performs the access as two 16-bit half-word cycles on an external asynchronous SRAM. While an access is in flight it holds `ready` low; the hazard/freeze logic stalls every pipeline register on `~ready`.

## Interface
Parameters:
- `BASE_ADDR`, default 1024: byte address mapped to SRAM word 0.
- `ACCESS_CYCLES`, default 2: clock cycles per 16-bit half access. Legal range is ≥1.

Ports (clock is `clk`; reset is `rst`, asynchronous and active-high):
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous active-high reset.
- `wr_en`  in  1  store request; held stable by the pipeline until `ready`.
- `rd_en`  in  1  load request; held stable by the pipeline until `ready`.
- `address`  in  32  byte address from the ALU result.
- `write_data`  in  32  store data.
- `read_data`  out  32  load data; registered.
- `ready`  out  1  access complete, or no request pending.
- `SRAM_DQ`  inout  16  SRAM data bus.
- `SRAM_ADDR`  out  18  SRAM half-word address.
- `SRAM_WE_N`  out  1  write enable, active-low.
- `SRAM_UB_N`, `SRAM_LB_N`, `SRAM_CE_N`, `SRAM_OE_N`  out  1 each  tied to 0.

## Operation
- Address map:
  - `word = (address - BASE_ADDR) >> 2`, taking bits [16:0].
  - `SRAM_ADDR = {word, half}`, where `half` is 0 for the low half and 1 for the high half.
  - Out-of-range addresses wrap modulo 2^17 words. No error is signalled.
  - `address[1:0]` is ignored.
- States:
  - `IDLE`:
    - If `wr_en` is high, go to `LOW` with the write flag set.
    - Otherwise, if `rd_en` is high, go to `LOW` with the write flag clear.
    - If both are high, the request is a write.
    - Otherwise, stay in `IDLE`.
  - `LOW`: drive the low half (`half`=0) for ACCESS_CYCLES cycles, then go to `HIGH`.
  - `HIGH`: drive the high half (`half`=1) for ACCESS_CYCLES cycles, then go to `DONE`.
  - `DONE`: one cycle, then return to `IDLE` unconditionally.
- `ready` is combinational: 1 in `DONE`, or in `IDLE` with neither `rd_en` nor `wr_en` asserted. It is 0 otherwise, so a new request freezes the pipeline in the same cycle it appears.
- Writes:
  - In `LOW`/`HIGH`, drive `SRAM_DQ` with `write_data[15:0]` / `write_data[31:16]`.
  - Hold `SRAM_WE_N`=0 for all ACCESS_CYCLES of each half.
  - Drive `SRAM_DQ` to high-Z in every other state and during all reads.
- Reads:
  - On the last cycle of `LOW`, register `SRAM_DQ` into `read_data[15:0]`.
  - On the last cycle of `HIGH`, register it into `read_data[31:16]`.
  - `read_data` holds until the next read overwrites it. Writes do not change it.
- A cycle counter is cleared on every state entry. Its width is clog2(ACCESS_CYCLES)+1.
- `write_data`, `address` and the request flags are not latched; they are sampled directly each cycle. The pipeline guarantees they are stable until `ready`.

## Timing
- Reset values:
  - State `IDLE`, counter 0, `read_data` 0.
  - `SRAM_WE_N` 1, `SRAM_DQ` high-Z, `SRAM_ADDR` 0.
  - `ready` equals `~(rd_en|wr_en)`.
- Request seen in `IDLE` at cycle 0:
  - `LOW` occupies cycles 1..N and `HIGH` occupies cycles N+1..2N, where N = ACCESS_CYCLES.
  - `DONE` is cycle 2N+1.
  - `ready` is low for 2N+1 cycles and high in cycle 2N+1. With N=2, `ready` rises in cycle 5.
- `read_data` is fully valid from the start of `DONE`.
- The pipeline advances at the end of `DONE`. A back-to-back request is seen in the following `IDLE` cycle, giving a minimum 2N+2 cycles per access.
- Reset asserted mid-access:
  - The access aborts immediately. `SRAM_WE_N` goes to 1 and `SRAM_DQ` goes to high-Z asynchronously.
  - A write may leave only its low half stored. This is accepted; no recovery is required.
- Request deasserted mid-access (a protocol violation): the FSM completes the sequence anyway.

## Structure
- Shared package `sram_pkg` holds:
  - The state enum (`IDLE`, `LOW`, `HIGH`, `DONE`).
  - `SRAM_DATA_W`=16 and `SRAM_ADDR_W`=18.
  - The default `BASE_ADDR`.
- No sub-module. The tri-state driver and cycle counter are inline.

## Test plan
- **Idle:** no request for 10 cycles → `ready`=1, `SRAM_WE_N`=1, `SRAM_DQ` high-Z, `read_data`=0.
- **Write:** `wr_en`=1, `address`=1024, `write_data`=0xDEADBEEF, N=2 → SRAM model word 0 = 0xBEEF, word 1 = 0xDEAD; `ready` rises in cycle 5; `SRAM_WE_N` low for exactly 4 cycles.
- **Read back:** `rd_en`=1, `address`=1024 after the write above → `read_data`=0xDEADBEEF at `DONE`. Then `address`=1028 with SRAM words 2/3 = 0x5678/0x1234 → `read_data`=0x12345678.
- **Simultaneous and back-to-back:** `wr_en`=`rd_en`=1 → treated as a write, `read_data` unchanged. Write then read with no gap → second access starts the cycle after `DONE`, with 6 cycles per access.
- **Reset mid-write:** assert `rst` in the first `HIGH` cycle → state `IDLE` and `SRAM_WE_N`=1 immediately; SRAM word 1 not written; the next request completes normally.
- **Parameter:** ACCESS_CYCLES=1 → `ready` rises in cycle 3; data is correct for both halves.
